pmp_region_encoder: RTL and testbench



---
 rtl/pmp_enc_pkg.sv | 33 +++
 rtl/pmp_region_classify.sv | 55 +++++
 rtl/pmp_region_encoder.sv | 130 +++++++++++++
 tb/tb_pmp_region_encoder.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmp_enc_pkg.sv
// pmp_enc_pkg: shared types for the PMP region encoder
package pmp_enc_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        TOR   = 2'd1,
        NA4   = 2'd2,
        NAPOT = 2'd3
    } pmp_addr_mode_t;

    typedef enum logic [2:0] {
        IDLE,
        ANALYZE,
        WR_PREV,
        WR_ENTRY,
        RESP
    } state_e;

    // Byte-to-pmpaddr shift at G=0; modules add their granularity on top.
    localparam int unsigned S = 2;

    // Wide enough for any pmpaddr; users slice down to PMP_LEN.
    localparam int unsigned AddrW = 64;

    typedef struct packed {
        pmp_addr_mode_t   mode;
        logic [AddrW-1:0] addr_prev;
        logic [AddrW-1:0] addr;
        logic [1:0]       entries;
        logic             err;
    } class_t;

endpackage

// File: rtl/pmp_region_classify.sv
// pmp_region_classify: combinational NA4/NAPOT/TOR classification and pmpaddr computation
// Ports: base_i/size_i byte region, idx_i target entry, res_o classification result.
module pmp_region_classify
    import pmp_enc_pkg::*;
#(
    parameter int unsigned PLEN           = 56,
    parameter int unsigned PMP_LEN        = 54,
    parameter int unsigned PMPGranularity = 0,
    parameter int unsigned IdxW           = 4
) (
    input  logic [PLEN-1:0] base_i,
    input  logic [PLEN-1:0] size_i,
    input  logic [IdxW-1:0] idx_i,
    output class_t          res_o
);
    localparam int unsigned Sh = S + PMPGranularity;
    localparam int unsigned KW = $clog2(PLEN);
    localparam logic [PLEN-1:0] GrainMask = PLEN'((64'd1 << Sh) - 64'd1);

    logic [PLEN:0]    top;
    logic [KW-1:0]    k;
    logic [AddrW-1:0] base_sh, top_sh, ones, addr;
    logic             zero, misal, carry, pow2, na4, napot, tor, idx0, tor_bad, fit, err;

    // Trailing-zero count of size: k = log2(size) when size is a power of two.
    always_comb begin
        k = '0;
        for (int i = PLEN - 1; i >= 0; i--) k = size_i[i] ? KW'(i) : k;
    end

    assign top     = {1'b0, base_i} + {1'b0, size_i};
    assign zero    = size_i == '0;
    assign misal   = |((base_i | size_i) & GrainMask);
    assign carry   = top[PLEN];
    assign pow2    = !zero && ((size_i & (size_i - PLEN'(1))) == '0);
    assign na4     = (PMPGranularity == 0) && (size_i == PLEN'(4));
    assign napot   = !na4 && pow2 && (k >= KW'(3 + PMPGranularity)) && ((base_i & (size_i - PLEN'(1))) == '0);
    assign tor     = !na4 && !napot;
    assign idx0    = idx_i == '0;
    assign tor_bad = tor && idx0 && (base_i != '0);
    assign base_sh = AddrW'(base_i) >> Sh;
    assign top_sh  = AddrW'(top[PLEN-1:0]) >> Sh;
    // NAPOT: trailing ones below a zero at bit t encode size 2^(t+3+G).
    assign ones    = napot ? (AddrW'(1) << (k - KW'(3 + PMPGranularity))) - AddrW'(1) : '0;
    assign addr    = tor ? top_sh : (base_sh | ones);
    assign fit     = ((addr >> PMP_LEN) == '0) && (!tor || ((base_sh >> PMP_LEN) == '0));
    assign err     = zero || misal || carry || !fit || tor_bad;

    assign res_o.mode      = err ? OFF : tor ? TOR : napot ? NAPOT : NA4;
    assign res_o.addr_prev = base_sh;
    assign res_o.addr      = addr;
    assign res_o.entries   = err ? 2'd0 : (tor && !idx0) ? 2'd2 : 2'd1;
    assign res_o.err       = err;

endmodule

// File: rtl/pmp_region_encoder.sv
// pmp_region_encoder: turns a byte region request into one or two PMP entry register writes
// Ports: req_* accepts base/size/idx (valid/ready); wr_* single-cycle entry writes;
//        rsp_* holds chosen mode, entries consumed and error until rsp_ready_i.
module pmp_region_encoder
    import pmp_enc_pkg::*;
#(
    parameter int unsigned PLEN           = 56,
    parameter int unsigned PMP_LEN        = 54,
    parameter int unsigned PMPGranularity = 0,
    parameter int unsigned NrEntries      = 16,
    parameter int unsigned IdxW           = $clog2(NrEntries)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [PLEN-1:0]    req_base_i,
    input  logic [PLEN-1:0]    req_size_i,
    input  logic [IdxW-1:0]    req_idx_i,
    output logic               wr_valid_o,
    output logic [IdxW-1:0]    wr_idx_o,
    output logic [PMP_LEN-1:0] wr_addr_o,
    output pmp_addr_mode_t     wr_mode_o,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output pmp_addr_mode_t     rsp_mode_o,
    output logic [1:0]         rsp_entries_o,
    output logic               rsp_err_o
);
    state_e             state_q;
    logic [PLEN-1:0]    base_q, size_q;
    logic [IdxW-1:0]    idx_q;
    logic [PMP_LEN-1:0] ent_addr_q;
    pmp_addr_mode_t     ent_mode_q;
    logic [1:0]         entries_q;
    class_t             cls;
    logic               unused_hi;

    pmp_region_classify #(
        .PLEN          (PLEN),
        .PMP_LEN       (PMP_LEN),
        .PMPGranularity(PMPGranularity),
        .IdxW          (IdxW)
    ) u_classify (
        .base_i(base_q),
        .size_i(size_q),
        .idx_i (idx_q),
        .res_o (cls)
    );

    // Bits above PMP_LEN are zero whenever err is clear.
    assign unused_hi = ^{cls.addr[AddrW-1:PMP_LEN], cls.addr_prev[AddrW-1:PMP_LEN]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            base_q        <= '0;
            size_q        <= '0;
            idx_q         <= '0;
            ent_addr_q    <= '0;
            ent_mode_q    <= OFF;
            entries_q     <= '0;
            req_ready_o   <= 1'b1;
            wr_valid_o    <= 1'b0;
            wr_idx_o      <= '0;
            wr_addr_o     <= '0;
            wr_mode_o     <= OFF;
            rsp_valid_o   <= 1'b0;
            rsp_mode_o    <= OFF;
            rsp_entries_o <= '0;
            rsp_err_o     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req_valid_i) begin
                    base_q      <= req_base_i;
                    size_q      <= req_size_i;
                    idx_q       <= req_idx_i;
                    req_ready_o <= 1'b0;
                    state_q     <= ANALYZE;
                end
                ANALYZE: begin
                    ent_addr_q <= cls.addr[PMP_LEN-1:0];
                    ent_mode_q <= cls.mode;
                    entries_q  <= cls.entries;
                    if (cls.err) begin
                        rsp_valid_o   <= 1'b1;
                        rsp_mode_o    <= OFF;
                        rsp_entries_o <= 2'd0;
                        rsp_err_o     <= 1'b1;
                        state_q       <= RESP;
                    end else if (cls.entries == 2'd2) begin
                        // TOR lower bound goes into the previous entry, left OFF.
                        wr_valid_o <= 1'b1;
                        wr_idx_o   <= idx_q - IdxW'(1);
                        wr_addr_o  <= cls.addr_prev[PMP_LEN-1:0];
                        wr_mode_o  <= OFF;
                        state_q    <= WR_PREV;
                    end else begin
                        wr_valid_o <= 1'b1;
                        wr_idx_o   <= idx_q;
                        wr_addr_o  <= cls.addr[PMP_LEN-1:0];
                        wr_mode_o  <= cls.mode;
                        state_q    <= WR_ENTRY;
                    end
                end
                WR_PREV: begin
                    wr_idx_o  <= idx_q;
                    wr_addr_o <= ent_addr_q;
                    wr_mode_o <= ent_mode_q;
                    state_q   <= WR_ENTRY;
                end
                WR_ENTRY: begin
                    wr_valid_o    <= 1'b0;
                    rsp_valid_o   <= 1'b1;
                    rsp_mode_o    <= ent_mode_q;
                    rsp_entries_o <= entries_q;
                    rsp_err_o     <= 1'b0;
                    state_q       <= RESP;
                end
                RESP: if (rsp_ready_i) begin
                    rsp_valid_o <= 1'b0;
                    req_ready_o <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pmp_region_encoder.sv
// tb_pmp_region_encoder: randomized and directed checks of the PMP region encoder for G=0..3
module tb_pmp_region_encoder;
    import pmp_enc_pkg::*;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_valid [4];
    logic           req_ready [4];
    logic [55:0]    base_in, size_in;
    logic [3:0]     idx_in;
    logic           rsp_ready;
    logic           wr_valid [4];
    logic [3:0]     wr_idx [4];
    logic [53:0]    wr_addr [4];
    pmp_addr_mode_t wr_mode [4];
    logic           rsp_valid [4];
    pmp_addr_mode_t rsp_mode [4];
    logic [1:0]     rsp_entries [4];
    logic           rsp_err [4];

    int total = 0;
    int bad = 0;

    int              obs_nwr, obs_lat;
    bit              obs_acc, obs_stable, obs_after;
    int              w_idx [2];
    longint unsigned w_addr [2];
    pmp_addr_mode_t  w_mode [2];
    int              w_cyc [2];
    pmp_addr_mode_t  o_mode;
    int              o_ent;
    bit              o_err;

    bit              e_err;
    pmp_addr_mode_t  e_mode;
    int              e_ent;
    int              e_idx [2];
    longint unsigned e_addr [2];
    pmp_addr_mode_t  e_wmode [2];

    longint unsigned tbl_addr [16];
    pmp_addr_mode_t  tbl_mode [16];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gen_dut
        pmp_region_encoder #(.PMPGranularity(g)) u_dut (
            .clk_i        (clk),
            .rst_i        (rst),
            .req_valid_i  (req_valid[g]),
            .req_ready_o  (req_ready[g]),
            .req_base_i   (base_in),
            .req_size_i   (size_in),
            .req_idx_i    (idx_in),
            .wr_valid_o   (wr_valid[g]),
            .wr_idx_o     (wr_idx[g]),
            .wr_addr_o    (wr_addr[g]),
            .wr_mode_o    (wr_mode[g]),
            .rsp_valid_o  (rsp_valid[g]),
            .rsp_ready_i  (rsp_ready),
            .rsp_mode_o   (rsp_mode[g]),
            .rsp_entries_o(rsp_entries[g]),
            .rsp_err_o    (rsp_err[g])
        );
    end

    // Reference: encoding rules stated with byte arithmetic, independent of any bit tricks.
    task automatic model(input int g, input longint unsigned b, input longint unsigned s, input int ix);
        longint unsigned grain = 64'd1 << (2 + g);
        longint unsigned top = b + s;
        int k = -1;
        for (int i = 0; i < 56; i++) if (s == (64'd1 << i)) k = i;
        e_err = 0;
        e_mode = OFF;
        e_ent = 0;
        if (s == 0 || b % grain != 0 || s % grain != 0 || top >= (64'd1 << 56)) e_err = 1;
        else if (g == 0 && s == 4) begin
            e_mode = NA4; e_ent = 1; e_idx[0] = ix; e_addr[0] = b / 4; e_wmode[0] = NA4;
        end else if (k >= 3 + g && b % s == 0) begin
            e_mode = NAPOT; e_ent = 1; e_idx[0] = ix; e_wmode[0] = NAPOT;
            e_addr[0] = b / grain + (64'd1 << (k - 3 - g)) - 1;
        end else if (ix == 0 && b != 0) e_err = 1;
        else if (ix == 0) begin
            e_mode = TOR; e_ent = 1; e_idx[0] = 0; e_addr[0] = top / grain; e_wmode[0] = TOR;
        end else begin
            e_mode = TOR; e_ent = 2;
            e_idx[0] = ix - 1; e_addr[0] = b / grain; e_wmode[0] = OFF;
            e_idx[1] = ix; e_addr[1] = top / grain; e_wmode[1] = TOR;
        end
        if (!e_err && (e_addr[0] >= (64'd1 << 54) || (e_ent == 2 && e_addr[1] >= (64'd1 << 54)))) e_err = 1;
        if (e_err) begin
            e_mode = OFF;
            e_ent = 0;
        end
    endtask

    // What a pmp_entry programmed with the captured writes would match.
    function automatic bit hit(int g, int ix, longint unsigned a);
        longint unsigned ad = tbl_addr[ix];
        longint unsigned pv = (ix > 0) ? tbl_addr[ix-1] : 64'd0;
        int sh = 2 + g;
        int t = 0;
        case (tbl_mode[ix])
            TOR: return a >= (pv << sh) && a < (ad << sh);
            NA4: return (a >> 2) == ad;
            NAPOT: begin
                while (t < 54 && ad[t]) t++;
                return (a >> (t + 1 + sh)) == (ad >> (t + 1));
            end
            default: return 0;
        endcase
    endfunction

    // Issues one request at the current negedge and records everything the DUT does with it.
    task automatic do_req(input int g, input longint unsigned b, input longint unsigned s, input int ix, input int hold);
        obs_nwr = 0;
        obs_lat = -1;
        obs_stable = 1;
        obs_after = 0;
        obs_acc = req_ready[g];
        base_in = b[55:0];
        size_in = s[55:0];
        idx_in = ix[3:0];
        req_valid[g] = 1'b1;
        @(negedge clk);
        req_valid[g] = 1'b0;
        base_in = 56'({$urandom(), $urandom()});
        size_in = 56'({$urandom(), $urandom()});
        idx_in = 4'($urandom());
        for (int c = 1; c <= 12 && obs_lat < 0; c++) begin
            if (wr_valid[g]) begin
                if (obs_nwr < 2) begin
                    w_idx[obs_nwr] = int'(wr_idx[g]);
                    w_addr[obs_nwr] = 64'(wr_addr[g]);
                    w_mode[obs_nwr] = wr_mode[g];
                    w_cyc[obs_nwr] = c;
                end
                obs_nwr++;
            end
            if (rsp_valid[g]) begin
                obs_lat = c;
                o_mode = rsp_mode[g];
                o_ent = int'(rsp_entries[g]);
                o_err = rsp_err[g];
                if (req_ready[g]) obs_stable = 0;
            end else @(negedge clk);
        end
        if (obs_lat < 0) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end else begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (!rsp_valid[g] || req_ready[g] || wr_valid[g] || rsp_mode[g] !== o_mode ||
                    int'(rsp_entries[g]) != o_ent || rsp_err[g] !== o_err) obs_stable = 0;
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            obs_after = !rsp_valid[g] && req_ready[g];
        end
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            total++;
            if (req_ready[g] !== 1'b1) begin bad++; $display("FAIL reset_req_ready g=%0d: got %b want 1", g, req_ready[g]); end
            total++;
            if (wr_valid[g] !== 1'b0 || rsp_valid[g] !== 1'b0) begin
                bad++; $display("FAIL reset_valids g=%0d: got wr=%b rsp=%b want 0 0", g, wr_valid[g], rsp_valid[g]);
            end
            total++;
            if ({rsp_mode[g], rsp_entries[g], rsp_err[g], wr_idx[g], wr_addr[g], wr_mode[g]} !== '0) begin
                bad++; $display("FAIL reset_data g=%0d: got mode=%0d ent=%0d err=%b idx=%0d addr=%h wmode=%0d want all 0",
                    g, rsp_mode[g], rsp_entries[g], rsp_err[g], wr_idx[g], wr_addr[g], wr_mode[g]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_na4();
        do_req(0, 64'h8000_0000, 64'd4, 3, 0);
        total++;
        if (obs_nwr != 1 || w_idx[0] != 3 || w_addr[0] != 64'h2000_0000 || w_mode[0] != NA4) begin
            bad++; $display("FAIL na4_write: got n=%0d idx=%0d addr=%h mode=%0d want 1 3 20000000 %0d", obs_nwr, w_idx[0], w_addr[0], w_mode[0], NA4);
        end
        total++;
        if (o_mode != NA4 || o_ent != 1 || o_err != 0 || obs_lat != 3) begin
            bad++; $display("FAIL na4_rsp: got mode=%0d ent=%0d err=%b lat=%0d want %0d 1 0 3", o_mode, o_ent, o_err, obs_lat, NA4);
        end
    endtask

    task automatic test_napot();
        longint unsigned want [2] = '{64'h2000_01FF, 64'h1000_00FF};
        for (int g = 0; g < 2; g++) begin
            do_req(g, 64'h8000_0000, 64'h1000, 5, 0);
            total++;
            if (obs_nwr != 1 || w_idx[0] != 5 || w_addr[0] != want[g] || w_mode[0] != NAPOT) begin
                bad++; $display("FAIL napot_write g=%0d: got n=%0d idx=%0d addr=%h mode=%0d want 1 5 %h %0d", g, obs_nwr, w_idx[0], w_addr[0], w_mode[0], want[g], NAPOT);
            end
            total++;
            if (o_mode != NAPOT || o_ent != 1 || o_err != 0 || obs_lat != 3) begin
                bad++; $display("FAIL napot_rsp g=%0d: got mode=%0d ent=%0d err=%b lat=%0d want %0d 1 0 3", g, o_mode, o_ent, o_err, obs_lat, NAPOT);
            end
        end
    endtask

    task automatic test_tor();
        do_req(0, 64'h1000, 64'h3000, 4, 0);
        total++;
        if (obs_nwr != 2 || w_idx[0] != 3 || w_addr[0] != 64'h400 || w_mode[0] != OFF) begin
            bad++; $display("FAIL tor_prev: got n=%0d idx=%0d addr=%h mode=%0d want 2 3 400 %0d", obs_nwr, w_idx[0], w_addr[0], w_mode[0], OFF);
        end
        total++;
        if (w_idx[1] != 4 || w_addr[1] != 64'h1000 || w_mode[1] != TOR || w_cyc[1] != w_cyc[0] + 1) begin
            bad++; $display("FAIL tor_entry: got idx=%0d addr=%h mode=%0d cyc=%0d/%0d want 4 1000 %0d consecutive", w_idx[1], w_addr[1], w_mode[1], w_cyc[0], w_cyc[1], TOR);
        end
        total++;
        if (o_mode != TOR || o_ent != 2 || o_err != 0 || obs_lat != 4) begin
            bad++; $display("FAIL tor_rsp: got mode=%0d ent=%0d err=%b lat=%0d want %0d 2 0 4", o_mode, o_ent, o_err, obs_lat, TOR);
        end
    endtask

    task automatic test_errors();
        longint unsigned eb [4] = '{64'h1002, 64'h1000, 64'h1000, (64'd1 << 56) - 4};
        longint unsigned es [4] = '{64'd4, 64'd0, 64'h3000, 64'd8};
        int ei [4] = '{1, 1, 0, 1};
        for (int n = 0; n < 4; n++) begin
            do_req(0, eb[n], es[n], ei[n], 0);
            total++;
            if (o_err != 1 || o_ent != 0 || o_mode != OFF || obs_nwr != 0 || obs_lat != 2) begin
                bad++; $display("FAIL err_case%0d: got err=%b ent=%0d mode=%0d writes=%0d lat=%0d want 1 0 0 0 2", n, o_err, o_ent, o_mode, obs_nwr, obs_lat);
            end
        end
    endtask

    task automatic test_hold_back_to_back();
        do_req(0, 64'h8000_0000, 64'h1000, 5, 5);
        total++;
        if (!obs_stable || !obs_after) begin
            bad++; $display("FAIL hold_stable: got stable=%b after=%b want 1 1", obs_stable, obs_after);
        end
        do_req(0, 64'h8000_0000, 64'd4, 2, 0);
        total++;
        if (!obs_acc || o_mode != NA4 || obs_lat != 3) begin
            bad++; $display("FAIL back_to_back: got acc=%b mode=%0d lat=%0d want 1 %0d 3", obs_acc, o_mode, obs_lat, NA4);
        end
    endtask

    task automatic test_reset_mid();
        bit seen_prev = 0;
        bit seen_late = 0;
        base_in = 56'h1000;
        size_in = 56'h3000;
        idx_in = 4'd4;
        req_valid[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        for (int c = 0; c < 8 && !seen_prev; c++) begin
            if (wr_valid[0] && wr_idx[0] == 4'd3) seen_prev = 1;
            else @(negedge clk);
        end
        total++;
        if (!seen_prev) begin bad++; $display("FAIL rstmid_prev_write: got none want idx=3 write"); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (wr_valid[0] !== 1'b0 || rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
            bad++; $display("FAIL rstmid_outputs: got wr=%b rsp=%b rdy=%b want 0 0 1", wr_valid[0], rsp_valid[0], req_ready[0]);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (wr_valid[0] || rsp_valid[0]) seen_late = 1;
        end
        total++;
        if (seen_late) begin bad++; $display("FAIL rstmid_late_activity: got write/rsp after reset want none"); end
    endtask

    task automatic test_random();
        longint unsigned b, s, grain;
        longint unsigned p [4];
        int ix, kind;
        for (int g = 0; g < 4; g++) begin
            grain = 64'd1 << (2 + g);
            for (int it = 0; it < 25; it++) begin
                kind = $urandom_range(0, 3);
                ix = $urandom_range(0, 15);
                case (kind)
                    0: begin
                        int k = $urandom_range(3 + g, 24);
                        s = 64'd1 << k;
                        b = 64'($urandom_range(1, 65535)) << k;
                    end
                    1: begin
                        b = 64'($urandom_range(1, 1 << 20)) * grain;
                        s = 64'($urandom_range(1, 4096)) * grain;
                    end
                    2: begin
                        b = (g == 0) ? 64'($urandom()) & ~64'd3 : 64'($urandom_range(0, 65535));
                        s = (g == 0 && $urandom_range(0, 1) == 1) ? 64'd4 : 64'($urandom_range(0, 64));
                    end
                    default: begin
                        b = 0;
                        ix = 0;
                        s = 64'($urandom_range(1, 4096)) * grain;
                    end
                endcase
                model(g, b, s, ix);
                tbl_mode[ix] = OFF;
                tbl_addr[ix] = 0;
                if (ix > 0) begin
                    tbl_mode[ix-1] = OFF;
                    tbl_addr[ix-1] = 0;
                end
                do_req(g, b, s, ix, $urandom_range(0, 2));
                total++;
                if (o_err != e_err || o_mode != e_mode || o_ent != e_ent || obs_lat != 2 + e_ent) begin
                    bad++; $display("FAIL rand_rsp g=%0d b=%h s=%h i=%0d: got err=%b mode=%0d ent=%0d lat=%0d want %b %0d %0d %0d",
                        g, b, s, ix, o_err, o_mode, o_ent, obs_lat, e_err, e_mode, e_ent, 2 + e_ent);
                end
                total++;
                if (obs_nwr != e_ent) begin
                    bad++; $display("FAIL rand_nwr g=%0d b=%h s=%h: got %0d want %0d", g, b, s, obs_nwr, e_ent);
                end
                for (int n = 0; n < e_ent && n < obs_nwr; n++) begin
                    total++;
                    if (w_idx[n] != e_idx[n] || w_addr[n] != e_addr[n] || w_mode[n] != e_wmode[n]) begin
                        bad++; $display("FAIL rand_write%0d g=%0d b=%h s=%h: got idx=%0d addr=%h mode=%0d want %0d %h %0d",
                            n, g, b, s, w_idx[n], w_addr[n], w_mode[n], e_idx[n], e_addr[n], e_wmode[n]);
                    end
                    tbl_addr[w_idx[n] & 15] = w_addr[n];
                    tbl_mode[w_idx[n] & 15] = w_mode[n];
                end
                if (!e_err && obs_nwr == e_ent) begin
                    p = '{b - 1, b, b + s - 1, b + s};
                    for (int q = 0; q < 4; q++) begin
                        if (q != 0 || b != 0) begin
                            total++;
                            if (hit(g, ix, p[q]) != (q == 1 || q == 2)) begin
                                bad++; $display("FAIL rand_roundtrip g=%0d b=%h s=%h probe=%h: got %b want %b", g, b, s, p[q], hit(g, ix, p[q]), q == 1 || q == 2);
                            end
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        for (int g = 0; g < 4; g++) req_valid[g] = 1'b0;
        base_in = '0;
        size_in = '0;
        idx_in = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_na4();
        test_napot();
        test_tor();
        test_errors();
        test_hold_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
